// File: rtl/pacote_pipeline.sv
// Shared types and constants for the ID/EX pipeline slice: control word layout,
// the NOP control value, the x0 address and the ALU operation encodings.
package pacote_pipeline;

   localparam int LARGURA_ALU_OP_PKG = 4;
   localparam int LARGURA_CTRL       = 7 + LARGURA_ALU_OP_PKG;

   typedef struct packed {
      logic                          escreve_reg;
      logic                          le_mem;
      logic                          escreve_mem;
      logic                          mem_para_reg;
      logic                          alu_src;
      logic                          branch;
      logic                          jump;
      logic [LARGURA_ALU_OP_PKG-1:0] alu_op;
   } ctrl_t;

   localparam ctrl_t       CTRL_NOP      = '0;
   localparam logic [4:0]  REG_ZERO      = 5'd0;
   localparam logic [15:0] CONTADOR_MAX  = 16'hFFFF;

   localparam logic [LARGURA_ALU_OP_PKG-1:0] ALU_ADD  = 4'd0;
   localparam logic [LARGURA_ALU_OP_PKG-1:0] ALU_SUB  = 4'd1;
   localparam logic [LARGURA_ALU_OP_PKG-1:0] ALU_AND  = 4'd2;
   localparam logic [LARGURA_ALU_OP_PKG-1:0] ALU_OR   = 4'd3;
   localparam logic [LARGURA_ALU_OP_PKG-1:0] ALU_XOR  = 4'd4;
   localparam logic [LARGURA_ALU_OP_PKG-1:0] ALU_SLL  = 4'd5;
   localparam logic [LARGURA_ALU_OP_PKG-1:0] ALU_SRL  = 4'd6;
   localparam logic [LARGURA_ALU_OP_PKG-1:0] ALU_SRA  = 4'd7;
   localparam logic [LARGURA_ALU_OP_PKG-1:0] ALU_SLT  = 4'd8;
   localparam logic [LARGURA_ALU_OP_PKG-1:0] ALU_SLTU = 4'd9;
   localparam logic [LARGURA_ALU_OP_PKG-1:0] ALU_LUI  = 4'd10;

endpackage

// File: rtl/detector_load_uso.sv
// Combinational load-use hazard detector: flags an ID instruction that reads the
// destination of a load currently sitting in EX. x0 never creates a hazard.
module detector_load_uso
   import pacote_pipeline::*;
(
   input  logic       valido_id,
   input  logic       valido_ex,
   input  logic       le_mem_ex,
   input  logic [4:0] rd_ex,
   input  logic [4:0] rs1_id,
   input  logic [4:0] rs2_id,
   input  logic       usa_rs1_id,
   input  logic       usa_rs2_id,
   output logic       bolha_load_uso
);

   logic casa_rs1;
   logic casa_rs2;

   assign casa_rs1 = usa_rs1_id & (rs1_id == rd_ex);
   assign casa_rs2 = usa_rs2_id & (rs2_id == rd_ex);

   assign bolha_load_uso = valido_id & valido_ex & le_mem_ex & (rd_ex != REG_ZERO)
                         & (casa_rs1 | casa_rs2);

endmodule

// File: rtl/registrador_id_ex.sv
// ID/EX pipeline register with load-use bubble insertion, stall/flush and a
// saturating bubble counter. Optional WB bypass on operand capture: ID_EX_BYPASS_WB_EN.
module registrador_id_ex
   import pacote_pipeline::*;
#(
   parameter int LARGURA_DADO   = 32,
   parameter int LARGURA_ALU_OP = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      valido_id,
   input  logic [LARGURA_DADO-1:0]   pc_id,
   input  logic [LARGURA_DADO-1:0]   dado_fonte1_id,
   input  logic [LARGURA_DADO-1:0]   dado_fonte2_id,
   input  logic [LARGURA_DADO-1:0]   imediato_id,
   input  logic [4:0]                rs1_id,
   input  logic [4:0]                rs2_id,
   input  logic [4:0]                rd_id,
   input  logic                      usa_rs1_id,
   input  logic                      usa_rs2_id,
   input  logic [6+LARGURA_ALU_OP:0] ctrl_id,
   input  logic                      parar_ex,
   input  logic                      limpar_ex,
   input  logic                      habilita_escrita_wb,
   input  logic [4:0]                endereco_destino_wb,
   input  logic [LARGURA_DADO-1:0]   dado_escrita_wb,
   output logic                      valido_ex,
   output logic [LARGURA_DADO-1:0]   pc_ex,
   output logic [LARGURA_DADO-1:0]   dado1_ex,
   output logic [LARGURA_DADO-1:0]   dado2_ex,
   output logic [LARGURA_DADO-1:0]   imediato_ex,
   output logic [4:0]                rs1_ex,
   output logic [4:0]                rs2_ex,
   output logic [4:0]                rd_ex,
   output logic [6+LARGURA_ALU_OP:0] ctrl_ex,
   output logic                      parar_if_id,
   output logic                      bolha_load_uso,
   output logic [15:0]               contador_bolhas
);

   logic                    valido_reg;
   logic [LARGURA_DADO-1:0] pc_reg;
   logic [LARGURA_DADO-1:0] dado1_reg;
   logic [LARGURA_DADO-1:0] dado2_reg;
   logic [LARGURA_DADO-1:0] imediato_reg;
   logic [4:0]              rs1_reg;
   logic [4:0]              rs2_reg;
   logic [4:0]              rd_reg;
   ctrl_t                   ctrl_reg;
   logic [15:0]             contador_reg;

   ctrl_t                   ctrl_entrada;
   ctrl_t                   ctrl_next;
   logic [LARGURA_DADO-1:0] dado1_next;
   logic [LARGURA_DADO-1:0] dado2_next;
   logic                    bolha;

   assign ctrl_entrada = ctrl_t'(ctrl_id);

   // Invalid slots carry a NOP; writes to x0 are squashed here so EX/MEM/WB never see them.
   always_comb begin
      ctrl_next = CTRL_NOP;
      if (valido_id) begin
         ctrl_next = ctrl_entrada;
         if (rd_id == REG_ZERO) ctrl_next.escreve_reg = 1'b0;
      end
   end

`ifdef ID_EX_BYPASS_WB_EN
   logic bypass1;
   logic bypass2;

   assign bypass1    = habilita_escrita_wb & (endereco_destino_wb != REG_ZERO)
                     & (endereco_destino_wb == rs1_id);
   assign bypass2    = habilita_escrita_wb & (endereco_destino_wb != REG_ZERO)
                     & (endereco_destino_wb == rs2_id);
   assign dado1_next = bypass1 ? dado_escrita_wb : dado_fonte1_id;
   assign dado2_next = bypass2 ? dado_escrita_wb : dado_fonte2_id;
`else
   logic unused_wb;

   assign unused_wb  = ^{habilita_escrita_wb, endereco_destino_wb, dado_escrita_wb};
   assign dado1_next = dado_fonte1_id;
   assign dado2_next = dado_fonte2_id;
`endif

   detector_load_uso u_detector (
      .valido_id      (valido_id),
      .valido_ex      (valido_reg),
      .le_mem_ex      (ctrl_reg.le_mem),
      .rd_ex          (rd_reg),
      .rs1_id         (rs1_id),
      .rs2_id         (rs2_id),
      .usa_rs1_id     (usa_rs1_id),
      .usa_rs2_id     (usa_rs2_id),
      .bolha_load_uso (bolha)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         valido_reg   <= 1'b0;
         pc_reg       <= '0;
         dado1_reg    <= '0;
         dado2_reg    <= '0;
         imediato_reg <= '0;
         rs1_reg      <= '0;
         rs2_reg      <= '0;
         rd_reg       <= '0;
         ctrl_reg     <= CTRL_NOP;
         contador_reg <= '0;
      end else if (limpar_ex) begin
         // Data fields are left as they are; a cleared valid/ctrl makes them harmless.
         valido_reg <= 1'b0;
         ctrl_reg   <= CTRL_NOP;
      end else if (parar_ex) begin
         valido_reg <= valido_reg;
      end else if (bolha) begin
         valido_reg <= 1'b0;
         ctrl_reg   <= CTRL_NOP;
         if (contador_reg != CONTADOR_MAX) contador_reg <= contador_reg + 16'd1;
      end else begin
         valido_reg   <= valido_id;
         pc_reg       <= pc_id;
         dado1_reg    <= dado1_next;
         dado2_reg    <= dado2_next;
         imediato_reg <= imediato_id;
         rs1_reg      <= rs1_id;
         rs2_reg      <= rs2_id;
         rd_reg       <= rd_id;
         ctrl_reg     <= ctrl_next;
      end
   end

   assign valido_ex       = valido_reg;
   assign pc_ex           = pc_reg;
   assign dado1_ex        = dado1_reg;
   assign dado2_ex        = dado2_reg;
   assign imediato_ex     = imediato_reg;
   assign rs1_ex          = rs1_reg;
   assign rs2_ex          = rs2_reg;
   assign rd_ex           = rd_reg;
   assign ctrl_ex         = ctrl_reg;
   assign contador_bolhas = contador_reg;
   assign bolha_load_uso  = bolha;
   assign parar_if_id     = parar_ex | (bolha & ~limpar_ex);

endmodule

// File: tb/tb_registrador_id_ex.sv
// Directed bench for registrador_id_ex: reset, normal flow, x0, load-use bubbles,
// flush/stall priority, WB bypass (ID_EX_BYPASS_WB_EN aware) and counter saturation.
module tb_registrador_id_ex;

   logic        clk;
   logic        reset;
   logic        valido_id;
   logic [31:0] pc_id;
   logic [31:0] dado_fonte1_id;
   logic [31:0] dado_fonte2_id;
   logic [31:0] imediato_id;
   logic [4:0]  rs1_id;
   logic [4:0]  rs2_id;
   logic [4:0]  rd_id;
   logic        usa_rs1_id;
   logic        usa_rs2_id;
   logic [10:0] ctrl_id;
   logic        parar_ex;
   logic        limpar_ex;
   logic        habilita_escrita_wb;
   logic [4:0]  endereco_destino_wb;
   logic [31:0] dado_escrita_wb;
   logic        valido_ex;
   logic [31:0] pc_ex;
   logic [31:0] dado1_ex;
   logic [31:0] dado2_ex;
   logic [31:0] imediato_ex;
   logic [4:0]  rs1_ex;
   logic [4:0]  rs2_ex;
   logic [4:0]  rd_ex;
   logic [10:0] ctrl_ex;
   logic        parar_if_id;
   logic        bolha_load_uso;
   logic [15:0] contador_bolhas;

   int erros;
   int checks;
   logic [15:0] bolhas_esperadas;

   // {escreve_reg, le_mem, escreve_mem, mem_para_reg, alu_src, branch, jump, alu_op}
   localparam logic [10:0] CTRL_ADD = 11'b1_0_0_0_0_0_0_0000;
   localparam logic [10:0] CTRL_LW  = 11'b1_1_0_1_1_0_0_0000;
   localparam logic [10:0] CTRL_SUB = 11'b1_0_0_0_0_0_0_0001;

   registrador_id_ex dut (
      .clk                 (clk),
      .reset               (reset),
      .valido_id           (valido_id),
      .pc_id               (pc_id),
      .dado_fonte1_id      (dado_fonte1_id),
      .dado_fonte2_id      (dado_fonte2_id),
      .imediato_id         (imediato_id),
      .rs1_id              (rs1_id),
      .rs2_id              (rs2_id),
      .rd_id               (rd_id),
      .usa_rs1_id          (usa_rs1_id),
      .usa_rs2_id          (usa_rs2_id),
      .ctrl_id             (ctrl_id),
      .parar_ex            (parar_ex),
      .limpar_ex           (limpar_ex),
      .habilita_escrita_wb (habilita_escrita_wb),
      .endereco_destino_wb (endereco_destino_wb),
      .dado_escrita_wb     (dado_escrita_wb),
      .valido_ex           (valido_ex),
      .pc_ex               (pc_ex),
      .dado1_ex            (dado1_ex),
      .dado2_ex            (dado2_ex),
      .imediato_ex         (imediato_ex),
      .rs1_ex              (rs1_ex),
      .rs2_ex              (rs2_ex),
      .rd_ex               (rd_ex),
      .ctrl_ex             (ctrl_ex),
      .parar_if_id         (parar_if_id),
      .bolha_load_uso      (bolha_load_uso),
      .contador_bolhas     (contador_bolhas)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; outputs are then sampled 1 time unit after it.
   task automatic ciclo();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] imm, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                         input logic u2, input logic [10:0] ctrl);
      valido_id      = v;
      pc_id          = pc;
      dado_fonte1_id = d1;
      dado_fonte2_id = d2;
      imediato_id    = imm;
      rs1_id         = rs1;
      rs2_id         = rs2;
      rd_id          = rd;
      usa_rs1_id     = u1;
      usa_rs2_id     = u2;
      ctrl_id        = ctrl;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      limpar_ex = 1'b0;
      parar_ex  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         set_id(1'b1, $urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
                5'($urandom), 1'b1, 1'b1, 11'($urandom));
         ciclo();
      end
      checks++;
      if (valido_ex !== 1'b0) begin erros++; $display("FAIL reset_valido got=%b exp=0", valido_ex); end
      checks++;
      if ({pc_ex, dado1_ex, dado2_ex, imediato_ex} !== 128'd0) begin
         erros++; $display("FAIL reset_dados got=%h/%h/%h/%h exp=0", pc_ex, dado1_ex, dado2_ex, imediato_ex);
      end
      checks++;
      if ({rs1_ex, rs2_ex, rd_ex, ctrl_ex} !== 26'd0) begin
         erros++; $display("FAIL reset_enderecos_ctrl got=%h/%h/%h/%h exp=0", rs1_ex, rs2_ex, rd_ex, ctrl_ex);
      end
      checks++;
      if (contador_bolhas !== 16'd0) begin erros++; $display("FAIL reset_contador got=%h exp=0", contador_bolhas); end
      // Reset mid-stall: parar_if_id follows parar_ex alone.
      parar_ex = 1'b1;
      ciclo();
      checks++;
      if (parar_if_id !== 1'b1 || valido_ex !== 1'b0) begin
         erros++; $display("FAIL reset_parado got=%b/%b exp=1/0", parar_if_id, valido_ex);
      end
      parar_ex = 1'b0;
      #1;
      checks++;
      if (parar_if_id !== 1'b0) begin erros++; $display("FAIL reset_parar_if_id got=%b exp=0", parar_if_id); end
      reset = 1'b0;
      bolhas_esperadas = 16'd0;
      $display("test_reset done");
   endtask

   task automatic test_normal();
      set_id(1'b1, 32'h100, 32'd5, 32'd1, 32'hFFFF_FFF0, 5'd2, 5'd3, 5'd4, 1'b1, 1'b1, CTRL_ADD);
      ciclo();
      checks++;
      if (valido_ex !== 1'b1 || pc_ex !== 32'h100 || dado1_ex !== 32'd5 || dado2_ex !== 32'd1) begin
         erros++; $display("FAIL normal_dados got=%b/%h/%h/%h exp=1/100/5/1", valido_ex, pc_ex, dado1_ex, dado2_ex);
      end
      checks++;
      if (rd_ex !== 5'd4 || rs1_ex !== 5'd2 || rs2_ex !== 5'd3 || imediato_ex !== 32'hFFFF_FFF0 || ctrl_ex !== CTRL_ADD) begin
         erros++; $display("FAIL normal_campos got=%h/%h/%h/%h/%h exp=4/2/3/fffffff0/%h",
                           rd_ex, rs1_ex, rs2_ex, imediato_ex, ctrl_ex, CTRL_ADD);
      end
      set_id(1'b1, 32'h104, 32'd9, 32'd7, 32'd0, 5'd1, 5'd1, 5'd0, 1'b1, 1'b1, CTRL_SUB);
      ciclo();
      checks++;
      if (ctrl_ex !== 11'b0_0_0_0_0_0_0_0001 || pc_ex !== 32'h104) begin
         erros++; $display("FAIL x0_escreve_reg got=%h/%h exp=001/104", ctrl_ex, pc_ex);
      end
      set_id(1'b0, 32'h108, 32'd3, 32'd3, 32'd0, 5'd1, 5'd1, 5'd7, 1'b1, 1'b1, CTRL_LW);
      ciclo();
      checks++;
      if (valido_ex !== 1'b0 || ctrl_ex !== 11'd0 || pc_ex !== 32'h108) begin
         erros++; $display("FAIL invalido_ctrl got=%b/%h/%h exp=0/000/108", valido_ex, ctrl_ex, pc_ex);
      end
      $display("test_normal done");
   endtask

   task automatic test_load_use();
      set_id(1'b1, 32'h200, 32'd0, 32'd0, 32'd8, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, CTRL_LW);
      ciclo();
      set_id(1'b1, 32'h204, 32'd11, 32'd22, 32'd0, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, CTRL_ADD);
      #1;
      checks++;
      if (bolha_load_uso !== 1'b1 || parar_if_id !== 1'b1) begin
         erros++; $display("FAIL load_uso_deteccao got=%b/%b exp=1/1", bolha_load_uso, parar_if_id);
      end
      ciclo();
      bolhas_esperadas++;
      checks++;
      if (valido_ex !== 1'b0 || ctrl_ex !== 11'd0 || contador_bolhas !== bolhas_esperadas) begin
         erros++; $display("FAIL load_uso_bolha got=%b/%h/%h exp=0/000/%h", valido_ex, ctrl_ex, contador_bolhas, bolhas_esperadas);
      end
      checks++;
      if (bolha_load_uso !== 1'b0 || parar_if_id !== 1'b0) begin
         erros++; $display("FAIL load_uso_libera got=%b/%b exp=0/0", bolha_load_uso, parar_if_id);
      end
      ciclo();
      checks++;
      if (valido_ex !== 1'b1 || pc_ex !== 32'h204 || rd_ex !== 5'd6 || dado1_ex !== 32'd11 || ctrl_ex !== CTRL_ADD) begin
         erros++; $display("FAIL load_uso_carrega got=%b/%h/%h/%h/%h exp=1/204/6/b/%h", valido_ex, pc_ex, rd_ex, dado1_ex, ctrl_ex, CTRL_ADD);
      end
      // Load to x0 never stalls.
      set_id(1'b1, 32'h208, 32'd0, 32'd0, 32'd0, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, CTRL_LW);
      ciclo();
      set_id(1'b1, 32'h20C, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, CTRL_ADD);
      #1;
      checks++;
      if (bolha_load_uso !== 1'b0 || parar_if_id !== 1'b0) begin
         erros++; $display("FAIL load_uso_x0 got=%b/%b exp=0/0", bolha_load_uso, parar_if_id);
      end
      ciclo();
      // lw x7 followed by an instruction whose unused rs2 field is 7.
      set_id(1'b1, 32'h210, 32'd0, 32'd0, 32'd0, 5'd2, 5'd0, 5'd7, 1'b1, 1'b0, CTRL_LW);
      ciclo();
      set_id(1'b1, 32'h214, 32'd0, 32'd0, 32'd0, 5'd1, 5'd7, 5'd8, 1'b1, 1'b0, CTRL_ADD);
      #1;
      checks++;
      if (bolha_load_uso !== 1'b0) begin erros++; $display("FAIL load_uso_sem_rs2 got=%b exp=0", bolha_load_uso); end
      usa_rs2_id = 1'b1;
      #1;
      checks++;
      if (bolha_load_uso !== 1'b1) begin erros++; $display("FAIL load_uso_rs2 got=%b exp=1", bolha_load_uso); end
      // A flush in the same cycle suppresses the stall and the counter.
      limpar_ex = 1'b1;
      #1;
      checks++;
      if (parar_if_id !== 1'b0) begin erros++; $display("FAIL load_uso_limpar_parar got=%b exp=0", parar_if_id); end
      ciclo();
      limpar_ex = 1'b0;
      checks++;
      if (valido_ex !== 1'b0 || contador_bolhas !== bolhas_esperadas) begin
         erros++; $display("FAIL load_uso_limpar got=%b/%h exp=0/%h", valido_ex, contador_bolhas, bolhas_esperadas);
      end
      $display("test_load_use done");
   endtask

   task automatic test_flush_stall();
      set_id(1'b1, 32'h300, 32'd1, 32'd2, 32'd3, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, CTRL_ADD);
      ciclo();
      set_id(1'b1, 32'h304, 32'd4, 32'd5, 32'd6, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, CTRL_SUB);
      limpar_ex = 1'b1;
      parar_ex  = 1'b1;
      ciclo();
      checks++;
      if (valido_ex !== 1'b0 || ctrl_ex !== 11'd0) begin
         erros++; $display("FAIL limpar_vence_parar got=%b/%h exp=0/000", valido_ex, ctrl_ex);
      end
      limpar_ex = 1'b0;
      parar_ex  = 1'b0;
      set_id(1'b1, 32'h308, 32'hA, 32'hB, 32'hC, 5'd7, 5'd8, 5'd9, 1'b1, 1'b1, CTRL_ADD);
      ciclo();
      parar_ex = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_id(1'b1, 32'h400 + 32'(i), 32'h55, 32'h66, 32'h77, 5'd10, 5'd11, 5'd12, 1'b1, 1'b1, CTRL_SUB);
         ciclo();
         checks++;
         if (valido_ex !== 1'b1 || pc_ex !== 32'h308 || dado1_ex !== 32'hA || rd_ex !== 5'd9 ||
             ctrl_ex !== CTRL_ADD || parar_if_id !== 1'b1) begin
            erros++; $display("FAIL parar_segura ciclo=%0d got=%b/%h/%h/%h/%h/%b exp=1/308/a/9/%h/1",
                              i, valido_ex, pc_ex, dado1_ex, rd_ex, ctrl_ex, parar_if_id, CTRL_ADD);
         end
      end
      parar_ex = 1'b0;
      ciclo();
      checks++;
      if (pc_ex !== 32'h402) begin erros++; $display("FAIL parar_retoma got=%h exp=402", pc_ex); end
      $display("test_flush_stall done");
   endtask

   task automatic test_bypass();
      logic [31:0] esperado;
`ifdef ID_EX_BYPASS_WB_EN
      esperado = 32'hDEAD;
`else
      esperado = 32'd1;
`endif
      habilita_escrita_wb = 1'b1;
      endereco_destino_wb = 5'd3;
      dado_escrita_wb     = 32'hDEAD;
      set_id(1'b1, 32'h500, 32'd1, 32'd2, 32'd0, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, CTRL_ADD);
      ciclo();
      checks++;
      if (dado1_ex !== esperado || dado2_ex !== 32'd2) begin
         erros++; $display("FAIL bypass_rs1 got=%h/%h exp=%h/2", dado1_ex, dado2_ex, esperado);
      end
      endereco_destino_wb = 5'd0;
      set_id(1'b1, 32'h504, 32'd1, 32'd2, 32'd0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, CTRL_ADD);
      ciclo();
      checks++;
      if (dado1_ex !== 32'd1 || dado2_ex !== 32'd2) begin
         erros++; $display("FAIL bypass_x0 got=%h/%h exp=1/2", dado1_ex, dado2_ex);
      end
      habilita_escrita_wb = 1'b0;
      $display("test_bypass done");
   endtask

   task automatic test_saturacao();
      @(negedge clk);
      force dut.contador_reg = 16'hFFFE;
      #1;
      release dut.contador_reg;
      bolhas_esperadas = 16'hFFFE;
      for (int i = 0; i < 2; i++) begin
         set_id(1'b1, 32'h600, 32'd0, 32'd0, 32'd0, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CTRL_LW);
         ciclo();
         set_id(1'b1, 32'h604, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, CTRL_ADD);
         ciclo();
         bolhas_esperadas = 16'hFFFF;
         checks++;
         if (contador_bolhas !== bolhas_esperadas || valido_ex !== 1'b0) begin
            erros++; $display("FAIL saturacao bolha=%0d got=%h/%b exp=%h/0", i, contador_bolhas, valido_ex, bolhas_esperadas);
         end
      end
      $display("test_saturacao done");
   endtask

   initial begin
      erros               = 0;
      checks              = 0;
      bolhas_esperadas    = 16'd0;
      reset               = 1'b1;
      parar_ex            = 1'b0;
      limpar_ex           = 1'b0;
      habilita_escrita_wb = 1'b0;
      endereco_destino_wb = 5'd0;
      dado_escrita_wb     = 32'd0;
      set_id(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 11'd0);
      test_reset();
      test_normal();
      test_load_use();
      test_flush_stall();
      test_bypass();
      test_saturacao();
      $display("Result: errors=%0d of %0d checks", erros, checks);
      $finish;
   end

endmodule
